// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared encodings and constants for the BCD-to-binary converter
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int CORR_THRESH   = 8;
  localparam int CORR_SUB      = 3;

endpackage

// File: rtl/bcd_nib_corr.sv
// rtl/bcd_nib_corr.sv - reverse double-dabble nibble correction: in>=8 ? in-3 : in
module bcd_nib_corr
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nib,
  output logic [BCD_DIGIT_W-1:0] corr
);

  assign corr = (nib >= BCD_DIGIT_W'(CORR_THRESH)) ? nib - BCD_DIGIT_W'(CORR_SUB) : nib;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter, one shift per clock
// Optional digit check (err output, bin forced to 0 on illegal digit) when BCD_BIN_CHECK_EN is defined.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in,
  output logic                        busy,
  output logic                        done,
  output logic [BW-1:0]               bin,
  output logic                        err
);

  localparam int DW  = BCD_DIGIT_W * NDIG;
  localparam int SRW = DW + BW;
  localparam int CW  = $clog2(BW + 1);

  bcd_state_t     state, state_nxt;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_shift;
  logic [SRW-1:0] sr_corr;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bin_r;
  logic           last_shift;

  assign sr_shift   = sr >> 1;
  assign last_shift = (cnt == CW'(BW - 1));

  // Only the BCD field is corrected; bits already shifted into the binary field are final.
  assign sr_corr[BW-1:0] = sr_shift[BW-1:0];

  for (genvar g = 0; g < NDIG; g++) begin : g_corr
    bcd_nib_corr u_corr (
      .nib  (sr_shift[BW + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .corr (sr_corr [BW + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef BCD_BIN_CHECK_EN
  logic digit_bad;
  logic flag;
  logic err_r;

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) digit_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag  <= 1'b0;
      err_r <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      flag  <= digit_bad;
      err_r <= 1'b0;
    end else if (state == ST_SHIFT && last_shift) begin
      err_r <= flag;
    end
  end

  assign err = err_r;
`else
  logic flag;

  assign flag = 1'b0;
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sr    <= '0;
      cnt   <= '0;
      bin_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sr  <= {bcd_in, {BW{1'b0}}};
            cnt <= '0;
          end
        end
        ST_SHIFT: begin
          sr  <= sr_corr;
          cnt <= cnt + 1'b1;
          if (last_shift) bin_r <= flag ? '0 : sr_corr[BW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign bin  = bin_r;

endmodule
